// File: rtl/ifetch_unit.sv
// ============================================================================
// ifetch_unit
// ----------------------------------------------------------------------------
// Instruction fetch front end for the RV64I datapath. Owns the fetch PC,
// issues in-order word reads to instruction memory, buffers the returned
// words in a small FIFO and hands them to the datapath tagged with their PC.
// A redirect flushes everything buffered or in flight and restarts fetch at
// the new target.
//
// Parameters:
//   RESET_PC        fetch PC loaded on reset
//   DEPTH           instruction FIFO entries (power of 2, >= 2)
//   MAX_OUTSTANDING max issued-but-unreturned memory requests
//
// Ports:
//   clk, rst_n              clock / asynchronous active-low reset
//   mem_req_valid/ready     fetch request handshake
//   mem_req_addr            word-aligned fetch address (current fetch PC)
//   mem_rsp_valid/data      in-order response word from memory
//   instr_valid/ready       delivery handshake to the datapath
//   instr_data, instr_pc    FIFO head word and its PC
//   redirect_valid/pc       one-cycle restart request and its target
// ============================================================================
module ifetch_unit #(
    parameter logic [63:0] RESET_PC        = 64'h0,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [63:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    // Architectural state
    logic [63:0]      fetch_pc;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      data_mem [DEPTH];
    logic [63:0]      pc_mem   [DEPTH];

    // Per-cycle decisions
    logic [SUM_W-1:0] credit_used;
    logic             issue_ok;
    logic             accept;
    logic             rsp_fire;
    logic             rsp_drop;
    logic             push;
    logic             pop;
    logic [63:0]      rsp_pc;
    logic [OUT_W-1:0] outstanding_next;

    // Request side. Every buffered word plus every in-flight request holds
    // one FIFO slot, so a returning response can never find the FIFO full.
    // Because the credit sum can only shrink while a request waits, the
    // request stays stable until accepted unless a redirect cancels it.
    // The request is also suppressed while reset is held.
    always_comb begin
        credit_used   = SUM_W'(fifo_count) + SUM_W'(outstanding);
        issue_ok      = (credit_used < SUM_W'(DEPTH)) &&
                        (outstanding < OUT_W'(MAX_OUTSTANDING));
        mem_req_valid = rst_n && issue_ok && !redirect_valid;
        mem_req_addr  = fetch_pc;
        accept        = mem_req_valid && mem_req_ready;
    end

    // Response side. Responses come back in request order, so the oldest
    // outstanding request is always the one returning. Stale responses
    // (issued before a redirect) sit at the front of that order and are
    // counted off by drop_cnt. Once they are gone every outstanding request
    // is live and consecutive, ending at fetch_pc-4, which gives the PC of
    // the returning word without a separate PC queue.
    always_comb begin
        rsp_fire         = mem_rsp_valid && (outstanding != '0);
        rsp_drop         = rsp_fire && ((drop_cnt != '0) || redirect_valid);
        push             = rsp_fire && !rsp_drop;
        rsp_pc           = fetch_pc - {{(64 - OUT_W - 2){1'b0}}, outstanding, 2'b00};
        outstanding_next = outstanding + OUT_W'(accept) - OUT_W'(rsp_fire);
    end

    // Delivery side. Outputs come only from registered FIFO state; the
    // data/pc read as zero whenever nothing is buffered.
    always_comb begin
        instr_valid = (fifo_count != '0);
        instr_data  = instr_valid ? data_mem[rd_ptr] : 32'h0;
        instr_pc    = instr_valid ? pc_mem[rd_ptr]   : 64'h0;
        pop         = instr_valid && instr_ready;
    end

    // Fetch PC: a redirect wins over an accept (the two never coincide since
    // the request is withheld during a redirect). Low two target bits are
    // forced to zero so fetch stays word aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~64'h3;
        end else if (accept) begin
            fetch_pc <= fetch_pc + 64'd4;
        end
    end

    // In-flight bookkeeping. On a redirect everything still outstanding after
    // this cycle's accept/response becomes stale and must be dropped; the
    // response arriving in the redirect cycle itself is already discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                drop_cnt <= outstanding_next;
            end else if (rsp_fire && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - OUT_W'(1);
            end
        end
    end

    // FIFO occupancy and pointers. A redirect empties the FIFO on the next
    // cycle; a pop in the redirect cycle is simply absorbed by the flush.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else if (redirect_valid) begin
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO storage. Contents need no reset since reads are masked by the
    // occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= mem_rsp_data;
            pc_mem[wr_ptr]   <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// ============================================================================
// tb_ifetch_unit
// ----------------------------------------------------------------------------
// Self-checking bench for ifetch_unit. A transaction-level reference keeps a
// queue of in-flight requests (with a stale flag) and a queue of buffered
// PCs; the instruction memory stub answers from the request queue with a
// per-request latency. Directed scenarios are followed by a randomized run.
// ============================================================================
module tb_ifetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk;
    logic        rst_n;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [63:0] instr_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    ifetch_unit #(
        .RESET_PC(RESET_PC),
        .DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_data(instr_data),
        .instr_pc(instr_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    // 10-unit clock period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [63:0] addr;
        bit          stale;
        int          due;
    } req_t;

    // Reference model state
    req_t        outQ[$];
    logic [63:0] fifoQ[$];
    logic [63:0] modelPc;
    int          cyc;
    int          latMin;
    int          latMax;
    bit          rspAlways;

    // Observations of the DUT used by directed checks
    int          dutAccepts;
    int          firstAccCyc;
    int          firstValCyc;

    int          nTests;
    int          nFail;

    // Instruction memory contents: the three directed words at 0/4/8, a
    // scrambled address pattern elsewhere.
    function automatic logic [31:0] memWord(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h00500093;
            64'h4:   return 32'h00600113;
            64'h8:   return 32'h002081B3;
            default: return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'hA5C3_0F17;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle. Called just after a falling edge: drive inputs, check
    // outputs against the model, advance the model, then move to the next
    // falling edge.
    task automatic applyStimulus(input bit rdy, input bit irdy, input bit redir,
                                 input logic [63:0] rpc);
        bit   expReq;
        bit   acc;
        bit   popIt;
        bit   rsp;
        req_t r;

        expReq = (fifoQ.size() + outQ.size() < DEPTH) && (outQ.size() < MAX_OUT) && !redir;
        rsp = 1'b0;
        if (outQ.size() > 0 && outQ[0].due <= cyc)
            rsp = rspAlways ? 1'b1 : ($urandom_range(0, 3) != 0);

        mem_req_ready  = rdy;
        instr_ready    = irdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        mem_rsp_valid  = rsp;
        mem_rsp_data   = rsp ? memWord(outQ[0].addr) : $urandom;
        #1;

        checkOutput("mem_req_valid", 64'(mem_req_valid), 64'(expReq));
        if (expReq)
            checkOutput("mem_req_addr", mem_req_addr, modelPc);
        checkOutput("instr_valid", 64'(instr_valid), 64'(fifoQ.size() > 0));
        if (fifoQ.size() > 0) begin
            checkOutput("instr_pc", instr_pc, fifoQ[0]);
            checkOutput("instr_data", 64'(instr_data), 64'(memWord(fifoQ[0])));
        end

        if (mem_req_valid && mem_req_ready) begin
            if (dutAccepts == 0) firstAccCyc = cyc;
            dutAccepts++;
        end
        if (instr_valid && firstValCyc < 0) firstValCyc = cyc;

        acc   = expReq && rdy;
        popIt = (fifoQ.size() > 0) && irdy;
        if (popIt) void'(fifoQ.pop_front());
        if (rsp) begin
            r = outQ.pop_front();
            if (!r.stale && !redir) fifoQ.push_back(r.addr);
        end
        if (acc) begin
            r.addr  = modelPc;
            r.stale = 1'b0;
            r.due   = cyc + $urandom_range(latMin, latMax);
            outQ.push_back(r);
            modelPc = modelPc + 64'd4;
        end
        if (redir) begin
            fifoQ.delete();
            foreach (outQ[i]) outQ[i].stale = 1'b1;
            modelPc = rpc & ~64'h3;
        end

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Assert reset just after a falling edge, check the immediate reset
    // values, hold for two rising edges and release on a falling edge.
    task automatic doReset();
        rst_n          = 1'b0;
        mem_rsp_valid  = 1'b0;
        redirect_valid = 1'b0;
        mem_req_ready  = 1'b1;
        instr_ready    = 1'b0;
        #1;
        checkOutput("rst_instr_valid", 64'(instr_valid), 64'h0);
        checkOutput("rst_req_valid", 64'(mem_req_valid), 64'h0);
        checkOutput("rst_req_addr", mem_req_addr, RESET_PC);
        checkOutput("rst_instr_data", 64'(instr_data), 64'h0);
        checkOutput("rst_instr_pc", instr_pc, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        outQ.delete();
        fifoQ.delete();
        modelPc     = RESET_PC;
        dutAccepts  = 0;
        firstAccCyc = -1;
        firstValCyc = -1;
    endtask

    // Safety net in case the run stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] rpc;
        bit          redir;
        int          n;

        nTests         = 0;
        nFail          = 0;
        cyc            = 0;
        rst_n          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'h0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        latMin         = 1;
        latMax         = 1;
        rspAlways      = 1'b1;
        @(negedge clk);

        // Streaming with 1-cycle memory; first word two cycles after accept
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
        checkOutput("first_latency", 64'(firstValCyc - firstAccCyc), 64'd2);

        // Consumer stalled: exactly DEPTH requests, then drain and resume
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        checkOutput("stall_accepts", 64'(dutAccepts), 64'(DEPTH));
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);

        // Memory not ready: request held at the reset PC
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
        checkOutput("noready_accepts", 64'(dutAccepts), 64'h0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);

        // Latency 3, two requests in flight, redirect to 0x100
        doReset();
        latMin = 3;
        latMax = 3;
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'h100);
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);

        // Redirect landing on the pop of PC 0x8 and a stale response
        doReset();
        latMin = 2;
        latMax = 2;
        n = 0;
        while (n < 40) begin
            redir = (fifoQ.size() > 0) && (fifoQ[0] == 64'h8) &&
                    (outQ.size() > 0) && (outQ[0].due <= cyc);
            applyStimulus(1'b1, 1'b1, redir, 64'h203);
            n = redir ? 40 : n + 1;
        end
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);

        // Reset while the FIFO holds three entries
        doReset();
        latMin = 1;
        latMax = 1;
        n = 0;
        while (fifoQ.size() < 3 && n < 20) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
            n++;
        end
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);

        // Randomized traffic
        latMin    = 1;
        latMax    = 4;
        rspAlways = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset();
            end else begin
                redir = ($urandom_range(0, 19) == 0);
                case ($urandom_range(0, 3))
                    0:       rpc = 64'hFFFF_FFFF_FFFF_FFF4 | 64'($urandom_range(0, 3));
                    1:       rpc = {$urandom, $urandom};
                    default: rpc = 64'($urandom_range(0, 255)) << 2;
                endcase
                applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, redir, rpc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
